button_event_gen: RTL and testbench

BUTTON_EVENT_GEN -- requirements
Module: button_event_gen

---
 rtl/button_event_gen.sv | 189 ++++++++++++++++++
 tb/tb_button_event_gen.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/button_event_gen.sv
// Debounced button event generator: per-channel 2-flop sync, debounce FSM, press/release/auto-repeat pulses.
// Optional auto-repeat (hold/repeat timers) enabled by macro BUTTON_EVENT_GEN_AUTO_REPEAT_EN.
module button_event_gen #(
  parameter int NUM_BTNS        = 2,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int HOLD_CYCLES     = 50000000,
  parameter int REPEAT_CYCLES   = 10000000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_BTNS-1:0] btn_raw,
  output logic [NUM_BTNS-1:0] btn_level,
  output logic [NUM_BTNS-1:0] press_pulse,
  output logic [NUM_BTNS-1:0] release_pulse,
  output logic [NUM_BTNS-1:0] repeat_pulse
);

  if (NUM_BTNS < 1 || NUM_BTNS > 8) begin : g_bad_num_btns
    $error("NUM_BTNS must be 1..8");
  end
  if (DEBOUNCE_CYCLES < 2 || HOLD_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_bad_cycles
    $error("cycle parameters must be >= 2");
  end

  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  // The sample that leaves IDLE/PRESSED is the first of the run, so the
  // counter only has to reach DEBOUNCE_CYCLES-2 before the final sample.
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 2);

`ifdef BUTTON_EVENT_GEN_AUTO_REPEAT_EN
  localparam int HW = $clog2(HOLD_CYCLES);
  localparam int RW = $clog2(REPEAT_CYCLES);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [RW-1:0] REP_LAST  = RW'(REPEAT_CYCLES - 1);
`endif

  typedef enum logic [2:0] {
    IDLE,
    ARM_PRESS,
    PRESSED,
    REPEAT,
    ARM_RELEASE
  } state_t;

  for (genvar g = 0; g < NUM_BTNS; g++) begin : g_ch
    state_t        state_q, state_d;
    logic [1:0]    sync_q, sync_d;
    logic [DW-1:0] deb_cnt_q, deb_cnt_d;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic          rel_q, rel_d;
    logic          in_s;
`ifdef BUTTON_EVENT_GEN_AUTO_REPEAT_EN
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic [RW-1:0] rep_cnt_q, rep_cnt_d;
    logic          rpt_q, rpt_d;
`endif

    assign in_s = sync_q[1];

    always_comb begin
      sync_d = {sync_q[0], btn_raw[g]};
    end

    always_comb begin
      state_d   = state_q;
      deb_cnt_d = deb_cnt_q;
      press_d   = 1'b0;
      rel_d     = 1'b0;
`ifdef BUTTON_EVENT_GEN_AUTO_REPEAT_EN
      hold_cnt_d = hold_cnt_q;
      rep_cnt_d  = rep_cnt_q;
      rpt_d      = 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (in_s) begin
            state_d   = ARM_PRESS;
            deb_cnt_d = '0;
          end
        end
        ARM_PRESS: begin
          if (!in_s) begin
            state_d   = IDLE;
            deb_cnt_d = '0;
          end else if (deb_cnt_q == DB_LAST) begin
            state_d   = PRESSED;
            deb_cnt_d = '0;
            press_d   = 1'b1;
`ifdef BUTTON_EVENT_GEN_AUTO_REPEAT_EN
            hold_cnt_d = '0;
`endif
          end else if (deb_cnt_q < DB_LAST) begin
            deb_cnt_d = deb_cnt_q + 1'b1;
          end
        end
        PRESSED: begin
          if (!in_s) begin
            state_d   = ARM_RELEASE;
            deb_cnt_d = '0;
          end
`ifdef BUTTON_EVENT_GEN_AUTO_REPEAT_EN
          else if (hold_cnt_q == HOLD_LAST) begin
            state_d   = REPEAT;
            rep_cnt_d = '0;
            rpt_d     = 1'b1;
          end else if (hold_cnt_q < HOLD_LAST) begin
            hold_cnt_d = hold_cnt_q + 1'b1;
          end
`endif
        end
`ifdef BUTTON_EVENT_GEN_AUTO_REPEAT_EN
        REPEAT: begin
          if (!in_s) begin
            state_d   = ARM_RELEASE;
            deb_cnt_d = '0;
          end else if (rep_cnt_q == REP_LAST) begin
            rep_cnt_d = '0;
            rpt_d     = 1'b1;
          end else if (rep_cnt_q < REP_LAST) begin
            rep_cnt_d = rep_cnt_q + 1'b1;
          end
        end
`endif
        ARM_RELEASE: begin
          if (in_s) begin
            // Bounce back to pressed: restart the hold timer, no new press event.
            state_d   = PRESSED;
            deb_cnt_d = '0;
`ifdef BUTTON_EVENT_GEN_AUTO_REPEAT_EN
            hold_cnt_d = '0;
`endif
          end else if (deb_cnt_q == DB_LAST) begin
            state_d   = IDLE;
            deb_cnt_d = '0;
            rel_d     = 1'b1;
          end else if (deb_cnt_q < DB_LAST) begin
            deb_cnt_d = deb_cnt_q + 1'b1;
          end
        end
        default: begin
          state_d   = IDLE;
          deb_cnt_d = '0;
        end
      endcase
      level_d = (state_d == PRESSED) || (state_d == REPEAT) || (state_d == ARM_RELEASE);
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        state_q   <= IDLE;
        sync_q    <= '0;
        deb_cnt_q <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        rel_q     <= 1'b0;
      end else begin
        state_q   <= state_d;
        sync_q    <= sync_d;
        deb_cnt_q <= deb_cnt_d;
        level_q   <= level_d;
        press_q   <= press_d;
        rel_q     <= rel_d;
      end
    end

`ifdef BUTTON_EVENT_GEN_AUTO_REPEAT_EN
    always_ff @(posedge clk) begin
      if (reset) begin
        hold_cnt_q <= '0;
        rep_cnt_q  <= '0;
        rpt_q      <= 1'b0;
      end else begin
        hold_cnt_q <= hold_cnt_d;
        rep_cnt_q  <= rep_cnt_d;
        rpt_q      <= rpt_d;
      end
    end
    assign repeat_pulse[g] = rpt_q;
`else
    assign repeat_pulse[g] = 1'b0;
`endif

    assign btn_level[g]     = level_q;
    assign press_pulse[g]   = press_q;
    assign release_pulse[g] = rel_q;
  end

endmodule

// File: tb/tb_button_event_gen.sv
// Directed bench for button_event_gen with DEBOUNCE=4, HOLD=8, REPEAT=3, NUM_BTNS=2.
// Cycle c starts 1 time unit after posedge c; outputs are observed there, then inputs for cycle c driven.
module tb_button_event_gen;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] btn_raw = 2'b00;
  logic [1:0] btn_level, press_pulse, release_pulse, repeat_pulse;

  int n_cmp = 0;
  int n_bad = 0;
  int viol  = 0;
  logic [1:0] prev_p, prev_r, prev_t;

  button_event_gen #(
    .NUM_BTNS(2), .DEBOUNCE_CYCLES(4), .HOLD_CYCLES(8), .REPEAT_CYCLES(3)
  ) dut (
    .clk(clk), .reset(reset), .btn_raw(btn_raw), .btn_level(btn_level),
    .press_pulse(press_pulse), .release_pulse(release_pulse), .repeat_pulse(repeat_pulse)
  );

  always #5 clk = ~clk;

  // Pulses must be mutually exclusive per channel and never last two cycles.
  always @(negedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        if (int'(press_pulse[i]) + int'(release_pulse[i]) + int'(repeat_pulse[i]) > 1) viol++;
        if ((press_pulse[i] && prev_p[i]) || (release_pulse[i] && prev_r[i]) ||
            (repeat_pulse[i] && prev_t[i])) viol++;
      end
    end
    prev_p = press_pulse;
    prev_r = release_pulse;
    prev_t = repeat_pulse;
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_level"}, int'(btn_level), 0);
    chk({nm, "_press"}, int'(press_pulse), 0);
    chk({nm, "_release"}, int'(release_pulse), 0);
    chk({nm, "_repeat"}, int'(repeat_pulse), 0);
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    btn_raw = 2'b00;
    tick();
    tick();
    chk_all_zero("reset");
    reset = 1'b0;
  endtask

  typedef struct {
    logic [1:0] raw;
    logic [1:0] lvl;
    logic [1:0] prs;
    logic [1:0] rel;
  } vec_t;

  vec_t tbl[18];

  initial begin
    int pc0, pc1, pcyc, rc, rcyc, rp0, rp1, rfirst, rlast, lv18, lv19, lvl36;
    int early_p, rel_cnt, ch1_lvl;

    // ch0: clean press cycle 0..9, release from 10; ch1: 4-cycle press 2..5.
    tbl[0]  = '{2'b01, 2'b00, 2'b00, 2'b00};
    tbl[1]  = '{2'b01, 2'b00, 2'b00, 2'b00};
    tbl[2]  = '{2'b11, 2'b00, 2'b00, 2'b00};
    tbl[3]  = '{2'b11, 2'b00, 2'b00, 2'b00};
    tbl[4]  = '{2'b11, 2'b00, 2'b00, 2'b00};
    tbl[5]  = '{2'b11, 2'b00, 2'b00, 2'b00};
    tbl[6]  = '{2'b01, 2'b01, 2'b01, 2'b00};
    tbl[7]  = '{2'b01, 2'b01, 2'b00, 2'b00};
    tbl[8]  = '{2'b01, 2'b11, 2'b10, 2'b00};
    tbl[9]  = '{2'b01, 2'b11, 2'b00, 2'b00};
    tbl[10] = '{2'b00, 2'b11, 2'b00, 2'b00};
    tbl[11] = '{2'b00, 2'b11, 2'b00, 2'b00};
    tbl[12] = '{2'b00, 2'b01, 2'b00, 2'b10};
    tbl[13] = '{2'b00, 2'b01, 2'b00, 2'b00};
    tbl[14] = '{2'b00, 2'b01, 2'b00, 2'b00};
    tbl[15] = '{2'b00, 2'b01, 2'b00, 2'b00};
    tbl[16] = '{2'b00, 2'b00, 2'b00, 2'b01};
    tbl[17] = '{2'b00, 2'b00, 2'b00, 2'b00};

    do_reset();
    for (int c = 0; c < 18; c++) begin
      tick();
      chk($sformatf("tbl%0d_level", c), int'(btn_level), int'(tbl[c].lvl));
      chk($sformatf("tbl%0d_press", c), int'(press_pulse), int'(tbl[c].prs));
      chk($sformatf("tbl%0d_release", c), int'(release_pulse), int'(tbl[c].rel));
      chk($sformatf("tbl%0d_repeat", c), int'(repeat_pulse), 0);
      btn_raw = tbl[c].raw;
    end

    // Glitch 1,1,0 then held on ch0; ch1 gets only three 1s (one short of debounce).
    do_reset();
    pc0 = 0; pc1 = 0; pcyc = -1; ch1_lvl = 0;
    for (int c = 0; c < 16; c++) begin
      tick();
      if (press_pulse[0]) begin pc0++; pcyc = c; end
      if (press_pulse[1]) pc1++;
      if (btn_level[1]) ch1_lvl++;
      btn_raw[0] = (c != 2);
      btn_raw[1] = (c < 3);
    end
    chk("glitch_press_count", pc0, 1);
    chk("glitch_press_cycle", pcyc, 9);
    chk("short_press_count", pc1, 0);
    chk("short_level_cycles", ch1_lvl, 0);

    // Release bounce 0,0,1 then steady 0 on ch0.
    do_reset();
    early_p = 0; rc = 0; rcyc = -1; lv18 = 0; lv19 = 1;
    for (int c = 0; c < 23; c++) begin
      tick();
      if (c == 6) chk("bounce_press_at6", int'(press_pulse[0]), 1);
      if (c > 6 && press_pulse[0]) early_p++;
      if (release_pulse[0]) begin rc++; rcyc = c; end
      if (c == 18) lv18 = int'(btn_level[0]);
      if (c == 19) lv19 = int'(btn_level[0]);
      btn_raw[0] = (c < 10) || (c == 12);
    end
    chk("bounce_extra_press", early_p, 0);
    chk("bounce_release_count", rc, 1);
    chk("bounce_release_cycle", rcyc, 19);
    chk("bounce_level_c18", lv18, 1);
    chk("bounce_level_c19", lv19, 0);

    // Both held for 37 cycles, then reset mid-hold and re-debounce.
    do_reset();
    rp0 = 0; rp1 = 0; rfirst = -1; rlast = -1; lvl36 = 0;
    for (int c = 0; c < 37; c++) begin
      tick();
      if (repeat_pulse[0]) rp0++;
      if (repeat_pulse[1]) begin
        rp1++;
        if (rfirst < 0) rfirst = c;
        rlast = c;
      end
      if (c == 36) lvl36 = int'(btn_level);
      btn_raw = 2'b11;
    end
    chk("hold_level_c36", lvl36, 3);
`ifdef BUTTON_EVENT_GEN_AUTO_REPEAT_EN
    chk("repeat1_count", rp1, 8);
    chk("repeat1_first", rfirst, 14);
    chk("repeat1_last", rlast, 35);
    chk("repeat0_count", rp0, 8);
`else
    chk("repeat1_count", rp1, 0);
    chk("repeat0_count", rp0, 0);
`endif
    tick();                  // cycle 37
    reset = 1'b1;
    tick();                  // cycle 38: reset applied at its edge
    chk_all_zero("midhold_reset");
    reset = 1'b0;
    early_p = 0; rel_cnt = 0;
    for (int c = 39; c <= 44; c++) begin
      tick();
      if (release_pulse != 2'b00) rel_cnt++;
      if (c < 44 && press_pulse != 2'b00) early_p++;
      if (c == 44) chk("repress_both_c44", int'(press_pulse), 3);
    end
    chk("repress_early", early_p, 0);
    chk("reset_no_release", rel_cnt, 0);

    tick();
    chk("pulse_exclusive", viol, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
